logic_capture: RTL

//  Upstream capture stage for the waveform display. Samples 5 logic channels on rising edges
//  of an external sample clock (logic_in[0]), oversampled in the clk domain. Arms on request,

---
 rtl/pockelizer_pkg.sv | 29 ++
 rtl/logic_capture_if.sv | 32 +++
 rtl/input_sync.sv | 25 ++
 rtl/logic_capture.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pockelizer_pkg.sv
// Shared capture definitions: state encoding and default window geometry, used by the
// capture stage and by the drawing sequencer for layout.
package pockelizer_pkg;

   localparam int unsigned CAP_CHANNELS    = 5;
   localparam int unsigned CAP_DEPTH       = 15;
   localparam int unsigned CAP_PRETRIG     = 3;
   localparam int unsigned CAP_SYNC_STAGES = 2;
   localparam int unsigned CAP_TIMEOUT_W   = 24;
   localparam int unsigned CAP_WAVE_W      = CAP_CHANNELS * CAP_DEPTH;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARM       = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } cap_state_e;

   // Bit position of sample smp (0 = oldest) of zero-based channel ch in wave_flat.
   function automatic int unsigned wave_bit_idx(input int unsigned ch, input int unsigned smp);
      return ch * CAP_DEPTH + smp;
   endfunction

   function automatic logic cap_busy(input cap_state_e st);
      return (st == ST_ARM) || (st == ST_WAIT_TRIG) || (st == ST_POST);
   endfunction

endpackage

// File: rtl/logic_capture_if.sv
// Capture handshake and frozen-window bus between the capture stage and the drawing sequencer.
interface logic_capture_if #(
   parameter int unsigned CHANNELS = pockelizer_pkg::CAP_CHANNELS,
   parameter int unsigned DEPTH    = pockelizer_pkg::CAP_DEPTH
) ();

   logic                      start;
   logic                      ack;
   logic                      busy;
   logic                      done;
   logic                      timed_out;
   logic [CHANNELS*DEPTH-1:0] wave_flat;

   modport master (
      output start,
      output ack,
      input  busy,
      input  done,
      input  timed_out,
      input  wave_flat
   );

   modport slave (
      input  start,
      input  ack,
      output busy,
      output done,
      output timed_out,
      output wave_flat
   );

endinterface

// File: rtl/input_sync.sv
// Flop-chain synchroniser for asynchronous input bits; every stage clears on reset.
module input_sync #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/logic_capture.sv
// Logic-analyser capture stage: oversamples CHANNELS inputs on an external sample clock,
// triggers on a ch1 transition and freezes a DEPTH-sample window. LOGIC_CAPTURE_TIMEOUT_EN adds a trigger timeout.
module logic_capture
   import pockelizer_pkg::*;
#(
   parameter int unsigned CHANNELS    = CAP_CHANNELS,
   parameter int unsigned DEPTH       = CAP_DEPTH,
   parameter int unsigned PRETRIG     = CAP_PRETRIG,
   parameter int unsigned SYNC_STAGES = CAP_SYNC_STAGES
`ifdef LOGIC_CAPTURE_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_W   = CAP_TIMEOUT_W
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CHANNELS:0] logic_in,
   logic_capture_if.slave  cap_if
);

   localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
   localparam int unsigned WIN_W     = CHANNELS * DEPTH;
   localparam int unsigned POST_N    = DEPTH - 1 - PRETRIG;
   localparam int unsigned POST_LAST = (POST_N == 0) ? 0 : POST_N - 1;

   cap_state_e         state_q, state_d;
   logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CHANNELS:0]  sync_s;
   logic               samp_prev_q;
   logic               samp_evt;
   logic               shift_en;
   logic               trig_hit;
   logic               force_trig;

   input_sync #(
      .WIDTH  (CHANNELS + 1),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (logic_in),
      .q_o   (sync_s)
   );

   // Rising edge of the synchronised sample clock; data comes from the same vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) samp_prev_q <= 1'b0;
      else        samp_prev_q <= sync_s[0];
   end

   assign samp_evt = sync_s[0] & ~samp_prev_q;
   assign trig_hit = sync_s[1] != win_q[DEPTH-1];

`ifdef LOGIC_CAPTURE_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
   logic                 timed_out_q, timed_out_d;
   logic                 start_acc;

   assign start_acc  = cap_if.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign force_trig = (to_cnt_q == '1);

   // Timeout counter runs only while waiting for a trigger and saturates at all-ones.
   always_comb begin
      to_cnt_d    = to_cnt_q;
      timed_out_d = timed_out_q;
      if ((state_q != ST_WAIT_TRIG) && (state_d == ST_WAIT_TRIG)) begin
         to_cnt_d = '0;
      end else if ((state_q == ST_WAIT_TRIG) && (to_cnt_q != '1)) begin
         to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
      end
      if (start_acc) begin
         timed_out_d = 1'b0;
      end else if ((state_q == ST_WAIT_TRIG) && samp_evt && force_trig) begin
         timed_out_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q    <= '0;
         timed_out_q <= 1'b0;
      end else begin
         to_cnt_q    <= to_cnt_d;
         timed_out_q <= timed_out_d;
      end
   end

   assign cap_if.timed_out = timed_out_q;
`else
   assign force_trig       = 1'b0;
   assign cap_if.timed_out = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cap_if.start) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (samp_evt && (fill_cnt_q == CNT_W'(PRETRIG))) state_d = ST_WAIT_TRIG;
         end
         ST_WAIT_TRIG: begin
            if (samp_evt && (trig_hit || force_trig)) begin
               state_d = (POST_N == 0) ? ST_DONE : ST_POST;
            end
         end
         ST_POST: begin
            if (samp_evt && (post_cnt_q == CNT_W'(POST_LAST))) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (cap_if.start)    state_d = ST_ARM;
            else if (cap_if.ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode; busy/done are registered from the next state so they track state_q.
   always_comb begin
      busy_d   = cap_busy(state_d);
      done_d   = (state_d == ST_DONE);
      shift_en = samp_evt && cap_busy(state_q);
   end

   // Window shift and fill/post counters.
   always_comb begin
      win_d      = win_q;
      fill_cnt_d = fill_cnt_q;
      post_cnt_d = post_cnt_q;
      if (shift_en) begin
         for (int c = 0; c < int'(CHANNELS); c++) begin
            win_d[c*DEPTH +: DEPTH] = {sync_s[c+1], win_q[c*DEPTH+1 +: DEPTH-1]};
         end
      end
      if ((state_q != ST_ARM) && (state_d == ST_ARM)) begin
         fill_cnt_d = '0;
      end else if ((state_q == ST_ARM) && samp_evt) begin
         fill_cnt_d = fill_cnt_q + CNT_W'(1);
      end
      if ((state_q == ST_WAIT_TRIG) && (state_d != ST_WAIT_TRIG)) begin
         post_cnt_d = '0;
      end else if ((state_q == ST_POST) && samp_evt) begin
         post_cnt_d = post_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q      <= '0;
         fill_cnt_q <= '0;
         post_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         win_q      <= win_d;
         fill_cnt_q <= fill_cnt_d;
         post_cnt_q <= post_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign cap_if.busy      = busy_q;
   assign cap_if.done      = done_q;
   assign cap_if.wave_flat = win_q;

endmodule
